// File: rtl/wb_slave_regfile.sv
// Pipelined Wishbone B4 slave register file: read-only ID at word 0, byte-lane writes,
// configurable response latency and outstanding-request limit.
module wb_slave_regfile #(
  parameter int          ADDR_WIDTH      = 16,
  parameter int          DATA_WIDTH      = 32,
  parameter int          GRANULE         = 8,
  parameter int          REGISTER_NUM    = 16,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] ID_VALUE        = 32'hB0B0_0001,
  localparam int         SEL_WIDTH       = DATA_WIDTH / GRANULE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  stall_o
);

  localparam int IDX_W = $clog2(REGISTER_NUM);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [SEL_WIDTH-1:0]  sel
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int k = 0; k < SEL_WIDTH; k++) begin
      if (sel[k]) res[k*GRANULE +: GRANULE] = new_w[k*GRANULE +: GRANULE];
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] regs [REGISTER_NUM];
  logic [CNT_W-1:0]      outstanding;
  logic                  accept;
  logic                  in_range;
  logic                  dec_err;
  logic                  resp;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  vld_p [LATENCY];
  logic                  err_p [LATENCY];
  logic [DATA_WIDTH-1:0] dat_p [LATENCY];

  // Request decode, evaluated against the registered outstanding count
  assign stall_o  = (outstanding >= CNT_W'(MAX_OUTSTANDING));
  assign accept   = cyc_i & stb_i & ~stall_o;
  assign in_range = (adr_i < ADDR_WIDTH'(REGISTER_NUM));
  assign dec_err  = ~in_range | (we_i & (adr_i == '0));
  assign idx      = adr_i[IDX_W-1:0];

  always_comb begin
    rd_data = '0;
    if (in_range) begin
      if (idx == '0) rd_data = DATA_WIDTH'(ID_VALUE);
      else           rd_data = regs[idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < REGISTER_NUM; i++) regs[i] <= '0;
    end else if (accept & we_i & ~dec_err) begin
      regs[idx] <= merge_lanes(regs[idx], dat_i, sel_i);
    end
  end

  // Response pipe: stage 0 loads at accept; dropping cyc_i abandons everything in flight
  always_ff @(posedge clk_i) begin
    if (rst_i | ~cyc_i) begin
      for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    err_p[0] <= dec_err;
    dat_p[0] <= we_i ? '0 : rd_data;
    for (int i = 1; i < LATENCY; i++) begin
      err_p[i] <= err_p[i-1];
      dat_p[i] <= dat_p[i-1];
    end
  end

  // Output stage
  assign resp  = vld_p[LATENCY-1];
  assign ack_o = resp & ~err_p[LATENCY-1];
  assign err_o = resp &  err_p[LATENCY-1];
  assign dat_o = ack_o ? dat_p[LATENCY-1] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i | ~cyc_i) begin
      outstanding <= '0;
    end else begin
      case ({accept, resp})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Directed bench for wb_slave_regfile: default instance (LATENCY=1) and a LATENCY=3,
// MAX_OUTSTANDING=2 instance sharing one clock and reset.
module tb_wb_slave_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic        cyc1 = 0, stb1 = 0, we1 = 0;
  logic [15:0] adr1 = '0;
  logic [31:0] dati1 = '0, dato1;
  logic [3:0]  sel1 = '0;
  logic        ack1, err1, stall1;

  logic        cyc3 = 0, stb3 = 0, we3 = 0;
  logic [15:0] adr3 = '0;
  logic [31:0] dati3 = '0, dato3;
  logic [3:0]  sel3 = '0;
  logic        ack3, err3, stall3;

  always #5 clk = ~clk;

  wb_slave_regfile dut1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc1), .stb_i(stb1), .we_i(we1), .adr_i(adr1),
    .dat_i(dati1), .sel_i(sel1), .dat_o(dato1), .ack_o(ack1), .err_o(err1), .stall_o(stall1)
  );

  wb_slave_regfile #(.LATENCY(3), .MAX_OUTSTANDING(2)) dut3 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc3), .stb_i(stb3), .we_i(we3), .adr_i(adr3),
    .dat_i(dati3), .sel_i(sel3), .dat_o(dato3), .ack_o(ack3), .err_o(err3), .stall_o(stall3)
  );

  // Single transaction; called at #1 after a rising edge. lat=1 means response seen
  // right after the accept edge.
  task automatic xfer(input bit u3, input logic we, input logic [15:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      output logic a, output logic e, output logic [31:0] d, output int lat);
    int guard = 0;
    if (u3) begin cyc3 = 1; stb3 = 1; we3 = we; adr3 = adr; dati3 = dat; sel3 = sel; end
    else    begin cyc1 = 1; stb1 = 1; we1 = we; adr1 = adr; dati1 = dat; sel1 = sel; end
    while ((u3 ? stall3 : stall1) && guard < 20) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    if (u3) stb3 = 0; else stb1 = 0;
    lat = 1;
    while (!(u3 ? (ack3 | err3) : (ack1 | err1)) && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    a = u3 ? ack3 : ack1;
    e = u3 ? err3 : err1;
    d = u3 ? dato3 : dato1;
  endtask

  task automatic test_reset();
    rst = 1; cyc1 = 1; stb1 = 1; we1 = 0; adr1 = 16'd3;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (ack1 !== 1'b0)  begin n_fail++; $display("FAIL rst_ack got %b want 0", ack1); end
    n_tests++; if (err1 !== 1'b0)  begin n_fail++; $display("FAIL rst_err got %b want 0", err1); end
    n_tests++; if (stall1 !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", stall1); end
    n_tests++; if (dato1 !== 32'h0) begin n_fail++; $display("FAIL rst_dat got %h want 0", dato1); end
    n_tests++; if (stall3 !== 1'b0) begin n_fail++; $display("FAIL rst_stall3 got %b want 0", stall3); end
    rst = 0;
    @(posedge clk); #1;
    n_tests++; if (ack1 !== 1'b1 || err1 !== 1'b0)
      begin n_fail++; $display("FAIL rst_read3_ack got ack=%b err=%b want ack=1 err=0", ack1, err1); end
    n_tests++; if (dato1 !== 32'h0) begin n_fail++; $display("FAIL rst_read3_dat got %h want 0", dato1); end
    stb1 = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_byte_lanes();
    logic a, e; logic [31:0] d; int lat;
    xfer(0, 1, 16'd3, 32'hDEAD_BEEF, 4'b1111, a, e, d, lat);
    n_tests++; if (a !== 1'b1 || e !== 1'b0 || lat != 1)
      begin n_fail++; $display("FAIL wr_full got ack=%b err=%b lat=%0d want 1 0 1", a, e, lat); end
    xfer(0, 1, 16'd3, 32'h1122_3344, 4'b0101, a, e, d, lat);
    n_tests++; if (a !== 1'b1 || e !== 1'b0 || lat != 1)
      begin n_fail++; $display("FAIL wr_lanes got ack=%b err=%b lat=%0d want 1 0 1", a, e, lat); end
    xfer(0, 0, 16'd3, 32'h0, 4'b0000, a, e, d, lat);
    n_tests++; if (a !== 1'b1 || lat != 1 || d !== 32'hDE22_BE44)
      begin n_fail++; $display("FAIL rd_lanes got ack=%b lat=%0d dat=%h want 1 1 de22be44", a, lat, d); end
    xfer(0, 1, 16'd3, 32'hFFFF_FFFF, 4'b0000, a, e, d, lat);
    n_tests++; if (a !== 1'b1 || e !== 1'b0)
      begin n_fail++; $display("FAIL wr_sel0 got ack=%b err=%b want 1 0", a, e); end
    xfer(0, 0, 16'd3, 32'h0, 4'b0000, a, e, d, lat);
    n_tests++; if (d !== 32'hDE22_BE44)
      begin n_fail++; $display("FAIL rd_sel0 got %h want de22be44", d); end
  endtask

  task automatic test_id_err();
    logic a, e; logic [31:0] d; int lat;
    xfer(0, 0, 16'd0, 32'h0, 4'b0000, a, e, d, lat);
    n_tests++; if (a !== 1'b1 || e !== 1'b0 || d !== 32'hB0B0_0001)
      begin n_fail++; $display("FAIL rd_id got ack=%b err=%b dat=%h want 1 0 b0b00001", a, e, d); end
    xfer(0, 1, 16'd0, 32'h1234_5678, 4'b1111, a, e, d, lat);
    n_tests++; if (a !== 1'b0 || e !== 1'b1 || lat != 1 || d !== 32'h0)
      begin n_fail++; $display("FAIL wr_id got ack=%b err=%b lat=%0d dat=%h want 0 1 1 0", a, e, lat, d); end
    xfer(0, 0, 16'd16, 32'h0, 4'b0000, a, e, d, lat);
    n_tests++; if (a !== 1'b0 || e !== 1'b1)
      begin n_fail++; $display("FAIL rd_oob got ack=%b err=%b want 0 1", a, e); end
    xfer(0, 0, 16'd0, 32'h0, 4'b0000, a, e, d, lat);
    n_tests++; if (a !== 1'b1 || d !== 32'hB0B0_0001)
      begin n_fail++; $display("FAIL rd_id2 got ack=%b dat=%h want 1 b0b00001", a, d); end
  endtask

  task automatic test_back_to_back();
    cyc1 = 1; stb1 = 1; we1 = 1; adr1 = 16'd7; dati1 = 32'hA5A5_5A5A; sel1 = 4'hF;
    @(posedge clk); #1;
    n_tests++; if (ack1 !== 1'b1 || err1 !== 1'b0)
      begin n_fail++; $display("FAIL b2b_wr got ack=%b err=%b want 1 0", ack1, err1); end
    we1 = 0;
    @(posedge clk); #1;
    n_tests++; if (ack1 !== 1'b1 || dato1 !== 32'hA5A5_5A5A)
      begin n_fail++; $display("FAIL b2b_rd got ack=%b dat=%h want 1 a5a55a5a", ack1, dato1); end
    stb1 = 0;
    @(posedge clk); #1;
    n_tests++; if (ack1 !== 1'b0 || err1 !== 1'b0)
      begin n_fail++; $display("FAIL b2b_idle got ack=%b err=%b want 0 0", ack1, err1); end
  endtask

  task automatic test_stall();
    logic a, e; logic [31:0] d; int lat;
    int acc_e[4]; int rsp_e[4]; logic [31:0] rsp_d[4];
    int na = 0, nr = 0, both = 0;
    logic stall_after2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      xfer(1, 1, 16'(k), 32'h100 + 32'(k), 4'hF, a, e, d, lat);
      n_tests++; if (a !== 1'b1 || lat != 3)
        begin n_fail++; $display("FAIL l3_wr%0d got ack=%b lat=%0d want 1 3", k, a, lat); end
    end
    @(posedge clk); #1;
    cyc3 = 1; stb3 = 1; we3 = 0; adr3 = 16'd1;
    for (int ed = 0; ed < 30 && nr < 4; ed++) begin
      logic acc;
      acc = stb3 && !stall3;
      @(posedge clk); #1;
      if (acc) begin
        if (na < 4) acc_e[na] = ed;
        na++;
        if (na == 2) stall_after2 = stall3;
        if (na < 4) adr3 = 16'(na + 1); else stb3 = 0;
      end
      if (ack3 && err3) both++;
      if (ack3 || err3) begin
        if (nr < 4) begin rsp_e[nr] = ed; rsp_d[nr] = dato3; end
        nr++;
      end
    end
    n_tests++; if (na != 4 || nr != 4)
      begin n_fail++; $display("FAIL stall_counts got acc=%0d rsp=%0d want 4 4", na, nr); end
    n_tests++; if (stall_after2 !== 1'b1)
      begin n_fail++; $display("FAIL stall_high got %b want 1", stall_after2); end
    n_tests++; if (both != 0)
      begin n_fail++; $display("FAIL stall_dual got %0d want 0", both); end
    if (na == 4 && nr == 4) begin
      n_tests++; if (acc_e[0] != 0 || acc_e[1] != 1 || acc_e[2] != 4 || acc_e[3] != 5)
        begin n_fail++; $display("FAIL stall_accepts got %0d %0d %0d %0d want 0 1 4 5",
                                 acc_e[0], acc_e[1], acc_e[2], acc_e[3]); end
      for (int k = 0; k < 4; k++) begin
        n_tests++; if (rsp_d[k] !== 32'h101 + 32'(k) || rsp_e[k] - acc_e[k] + 1 != 3)
          begin n_fail++; $display("FAIL stall_rsp%0d got dat=%h lat=%0d want %h 3",
                                   k, rsp_d[k], rsp_e[k] - acc_e[k] + 1, 32'h101 + 32'(k)); end
      end
    end
  endtask

  task automatic test_flush();
    logic a, e; logic [31:0] d; int lat; int seen = 0;
    cyc3 = 0; stb3 = 0;
    @(posedge clk); #1;
    cyc3 = 1; stb3 = 1; we3 = 1; adr3 = 16'd5; dati3 = 32'hCAFE_F00D; sel3 = 4'hF;
    @(posedge clk); #1;
    we3 = 0;
    @(posedge clk); #1;
    cyc3 = 0; stb3 = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (ack3 || err3) seen++;
    end
    n_tests++; if (seen != 0)
      begin n_fail++; $display("FAIL flush_resp got %0d responses want 0", seen); end
    n_tests++; if (stall3 !== 1'b0)
      begin n_fail++; $display("FAIL flush_stall got %b want 0", stall3); end
    xfer(1, 0, 16'd5, 32'h0, 4'h0, a, e, d, lat);
    n_tests++; if (a !== 1'b1 || d !== 32'hCAFE_F00D)
      begin n_fail++; $display("FAIL flush_keep got ack=%b dat=%h want 1 cafef00d", a, d); end
  endtask

  task automatic test_random();
    bit exp_q[$];
    int acc_cnt = 0, rsp_cnt = 0, flushed = 0;
    cyc3 = 0; stb3 = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 1010; c++) begin
      logic r, acc, ex;
      r = ack3 | err3;
      n_tests++; if (ack3 && err3)
        begin n_fail++; $display("FAIL rand_dual cycle %0d ack=1 err=1", c); end
      n_tests++; if (stall3 !== (exp_q.size() >= 2))
        begin n_fail++; $display("FAIL rand_stall cycle %0d got %b want %b", c, stall3, exp_q.size() >= 2); end
      if (r) begin
        rsp_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL rand_spurious cycle %0d got response want none", c);
        end else begin
          ex = exp_q.pop_front();
          n_tests++; if (err3 !== ex)
            begin n_fail++; $display("FAIL rand_err cycle %0d got %b want %b", c, err3, ex); end
        end
      end
      if (c < 1000) begin
        cyc3 = ($urandom_range(0, 9) != 0); stb3 = 1'($urandom_range(0, 1));
        we3 = 1'($urandom_range(0, 1)); adr3 = 16'($urandom_range(0, 17));
        dati3 = $urandom; sel3 = 4'($urandom_range(0, 15));
      end else begin
        cyc3 = 1; stb3 = 0;
      end
      acc = cyc3 && stb3 && !stall3;
      if (!cyc3) begin
        flushed += exp_q.size();
        exp_q.delete();
      end else if (acc) begin
        acc_cnt++;
        exp_q.push_back((adr3 >= 16) || (we3 && adr3 == 0));
      end
      @(posedge clk); #1;
    end
    n_tests++; if (exp_q.size() != 0 || rsp_cnt + flushed != acc_cnt)
      begin n_fail++; $display("FAIL rand_balance got rsp=%0d flushed=%0d pending=%0d want total %0d",
                               rsp_cnt, flushed, exp_q.size(), acc_cnt); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_byte_lanes();
    test_id_err();
    test_back_to_back();
    test_stall();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_slave_regfile.md
Name: wb_slave_regfile

Overview:
Pipelined Wishbone B4 slave holding REGISTER_NUM general registers of DATA_WIDTH bits, with byte-lane writes. Read-only ID register at word 0. It is the DUT our wb_property checker binds to: it produces ack_o/err_o/stall_o/dat_o from the interconnect's master-side request signals. The response pipeline depth and outstanding-request limit are configurable.

Parameters:
ADDR_WIDTH, 16, word-address width of adr_i
DATA_WIDTH, 32, data bus width
GRANULE, 8, bits per select lane
REGISTER_NUM, 16, number of words (word 0 = ID, 1..REGISTER_NUM-1 read/write); min 2
SEL_WIDTH, DATA_WIDTH/GRANULE, localparam, select width
LATENCY, 1, cycles from accept to ack/err; range 1..4
MAX_OUTSTANDING, 4, max accepted-but-unanswered requests; range 1..8
ID_VALUE, 32'hB0B0_0001, constant returned by word 0

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset; one clock, synchronous, active-high
cyc_i  in  1  bus cycle active
stb_i  in  1  request strobe
we_i  in  1  1 = write, 0 = read
adr_i  in  ADDR_WIDTH  word address
dat_i  in  DATA_WIDTH  write data
sel_i  in  SEL_WIDTH  byte-lane enables (writes only)
dat_o  out  DATA_WIDTH  read data, valid with ack_o
ack_o  out  1  successful completion
err_o  out  1  error completion
stall_o  out  1  request not accepted this cycle

Behaviour:
- Reset (rst_i=1 at edge): registers 1..N-1 = 0; pipeline valid bits cleared; outstanding = 0; ack_o=0, err_o=0, dat_o=0; stall_o=0 (combinational from outstanding). Reset mid-transaction drops all in-flight responses; no ack/err after reset.
- Accept = cyc_i & stb_i & !stall_o at a rising edge.
- stall_o = (outstanding >= MAX_OUTSTANDING), combinational from registered count only (no dependence on stb_i).
- Decode at accept: err if adr_i >= REGISTER_NUM, or (we_i & adr_i==0). Otherwise ok.
- Write ok: for each lane k with sel_i[k]=1, reg[adr_i][k*GRANULE +: GRANULE] <= dat_i lane, committed at the accept edge. sel_i=0 write: no change, still ack.
- Read ok: data sampled at accept edge (word 0 -> ID_VALUE); read of a word written in the same cycle returns old value; a read accepted the cycle after a write returns new value.
- Response pipe: LATENCY stages of {valid, err, data}; stage 0 loaded at accept; last stage drives ack_o = valid & !err, err_o = valid & err, dat_o = data when ack, 0 otherwise. LATENCY=1 -> ack/err in cycle after accept. ack_o and err_o never both 1; at most one response per cycle.
- Outstanding: +1 on accept, -1 when ack_o|err_o high at the edge; both -> unchanged. Saturation impossible by stall rule.
- cyc_i=0 at an edge: all pipe valid bits cleared, outstanding <= 0, ack_o/err_o forced 0 from next cycle; committed writes kept. stb_i ignored while cyc_i=0.
- Back-to-back accepts each cycle allowed when not stalled; responses return in order, one per cycle.

Test Plan:
- Reset with stb_i=1, cyc_i=1 held -> ack_o=0, err_o=0, stall_o=0 during and cycle after reset; reg 3 reads 0 afterwards.
- Write adr=3 dat=32'hDEAD_BEEF sel=4'b1111, then write adr=3 dat=32'h1122_3344 sel=4'b0101, then read adr=3 -> each ack one cycle after accept; read dat_o=32'hDE22_BE44.
- Read adr=0 -> ack, dat_o=32'hB0B0_0001; write adr=0 -> err_o=1, ack_o=0; read adr=16 -> err_o=1; re-read adr=0 unchanged.
- LATENCY=3, MAX_OUTSTANDING=2: stb_i held with 4 reads adr 1..4 -> stall_o high after 2 accepts, accepts resume as acks arrive; acks in address order, ack 3 cycles after each accept, never 2 responses in one cycle.
- LATENCY=3: accept write adr=5 then read adr=5, drop cyc_i next cycle -> no ack/err ever appears; later read adr=5 returns written value.
- Random stream 1000 cycles with cyc_i/stb_i toggling -> ack_o & err_o never both 1; acks+errs equal accepts not flushed by cyc_i drop; outstanding never > MAX_OUTSTANDING.
